// File: rtl/reg_scoreboard.sv
// Register file with per-register pending-write counters and a one-entry issue stage.
// Stalls decode on read-after-write hazards and on pending-counter saturation.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_PEND = 3,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
    localparam int unsigned CNT_W   = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              reg_dst,
    input  logic              reg_write_cu,
    input  logic [15:0]       inst_imm_field,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_sgn_imm,
    output logic [ADDR_W-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              stall_flag
);

    localparam int unsigned SUM_W = CNT_W + 2;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];

    logic [ADDR_W-1:0] dest_c;
    logic [DATA_W-1:0] rs_data_c;
    logic [DATA_W-1:0] rt_data_c;
    logic              rs_haz_c;
    logic              rt_haz_c;
    logic              sat_c;
    logic              issue_c;
    logic              wb_c;
    logic              fl_dec_c;

    // Pending count after one increment and up to two decrements, floored at zero.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec_a,
                                                  input logic dec_b);
        logic [SUM_W-1:0] up;
        logic [SUM_W-1:0] dn;
        up = SUM_W'(c) + SUM_W'(inc);
        dn = SUM_W'(dec_a) + SUM_W'(dec_b);
        return (dn >= up) ? '0 : CNT_W'(up - dn);
    endfunction

    assign wb_c     = wb_en && (wb_addr != '0);
    assign dest_c   = reg_dst ? rd_addr : rt_addr;
    assign fl_dec_c = flush && ex_valid && ex_reg_write && (ex_dest != '0);

    always_comb begin
        rs_data_c = '0;
        rt_data_c = '0;
        if (rs_addr != '0) begin
            rs_data_c = (wb_en && (wb_addr == rs_addr)) ? wb_data : regs_q[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data_c = (wb_en && (wb_addr == rt_addr)) ? wb_data : regs_q[rt_addr];
        end
    end

    // A source whose last pending write retires this cycle is already safe via bypass.
    always_comb begin
        rs_haz_c = rs_used && (rs_addr != '0) && (cnt_q[rs_addr] != '0)
                   && !((cnt_q[rs_addr] == CNT_W'(1)) && wb_en && (wb_addr == rs_addr));
        rt_haz_c = rt_used && (rt_addr != '0) && (cnt_q[rt_addr] != '0)
                   && !((cnt_q[rt_addr] == CNT_W'(1)) && wb_en && (wb_addr == rt_addr));
        sat_c    = reg_write_cu && (dest_c != '0) && (cnt_q[dest_c] == CNT_W'(MAX_PEND))
                   && !(wb_en && (wb_addr == dest_c));
    end

    assign id_ready   = !reset && !flush && !rs_haz_c && !rt_haz_c && !sat_c
                        && (!ex_valid || ex_ready);
    assign stall_flag = id_valid && !id_ready && !reset;
    assign issue_c    = id_valid && id_ready;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = '0;
            if (r != 0) begin
                cnt_d[r] = next_cnt(cnt_q[r],
                                    issue_c && reg_write_cu && (dest_c == ADDR_W'(r)),
                                    wb_c && (wb_addr == ADDR_W'(r)),
                                    fl_dec_c && (ex_dest == ADDR_W'(r)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            ex_valid     <= 1'b0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_sgn_imm   <= '0;
            ex_dest      <= '0;
            ex_reg_write <= 1'b0;
        end else begin
            if (wb_c) begin
                regs_q[wb_addr] <= wb_data;
            end
            cnt_q <= cnt_d;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (issue_c) begin
                ex_valid     <= 1'b1;
                ex_rs_data   <= rs_data_c;
                ex_rt_data   <= rt_data_c;
                ex_sgn_imm   <= DATA_W'($signed(inst_imm_field));
                ex_dest      <= dest_c;
                ex_reg_write <= reg_write_cu;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
